timer_channel_scheduler: RTL and testbench

Multi-channel egg-timer scheduler. Holds NCH independent mm:ss BCD countdown channels and time-shares one BCD decrementer between them. On each one-second tick it sweeps the running channels in order. Sits between the key/switch front end and the 7-segment decoders, and replaces the per-timer decrement path when more than one timer is needed.

---
 rtl/egg_timer_pkg.sv | 35 +++
 rtl/bcd_mmss_dec.sv | 37 +++
 rtl/timer_channel_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_timer_channel_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// Shared types and helpers for the multi-channel mm:ss BCD timer scheduler.
//   bcd_time_t    : packed {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
//   sched_state_t : sweep FSM states
//   clamp_time()  : forces a raw 16-bit BCD word into the legal 00:00..99:59 range
package egg_timer_pkg;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } sched_state_t;

  localparam logic [15:0] TIME_ZERO    = 16'h0000;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  DIGIT_MAX    = 4'd9;

  // Non-BCD digits saturate to 9; the tens-of-seconds digit saturates to 5.
  function automatic bcd_time_t clamp_time(input logic [15:0] raw);
    bcd_time_t t;
    t = raw;
    if (t.min_tens > DIGIT_MAX)    t.min_tens = DIGIT_MAX;
    if (t.min_ones > DIGIT_MAX)    t.min_ones = DIGIT_MAX;
    if (t.sec_tens > SEC_TENS_MAX) t.sec_tens = SEC_TENS_MAX;
    if (t.sec_ones > DIGIT_MAX)    t.sec_ones = DIGIT_MAX;
    return t;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of an mm:ss BCD time.
//   dec_in        : current time
//   dec_out       : time minus one second (00:00 stays at 00:00)
//   is_zero_after : dec_out is 00:00
module bcd_mmss_dec
  import egg_timer_pkg::*;
(
  input  bcd_time_t dec_in,
  output bcd_time_t dec_out,
  output logic      is_zero_after
);

  always_comb begin
    dec_out = dec_in;
    if (dec_in == TIME_ZERO) begin
      dec_out = TIME_ZERO;
    end else if (dec_in.sec_ones != 4'd0) begin
      dec_out.sec_ones = dec_in.sec_ones - 4'd1;
    end else begin
      // Borrow chain: each zero digit wraps to its maximum and borrows upward.
      dec_out.sec_ones = DIGIT_MAX;
      if (dec_in.sec_tens != 4'd0) begin
        dec_out.sec_tens = dec_in.sec_tens - 4'd1;
      end else begin
        dec_out.sec_tens = SEC_TENS_MAX;
        if (dec_in.min_ones != 4'd0) begin
          dec_out.min_ones = dec_in.min_ones - 4'd1;
        end else begin
          dec_out.min_ones = DIGIT_MAX;
          dec_out.min_tens = dec_in.min_tens - 4'd1;
        end
      end
    end
    is_zero_after = (dec_out == TIME_ZERO);
  end

endmodule

// File: rtl/timer_channel_scheduler.sv
// Multi-channel egg-timer scheduler: NCH mm:ss BCD countdown channels sharing
// one decrementer. Each tick starts a sweep (FETCH/WRITE per channel).
// Optional feature macro: AUTO_RELOAD_EN (expired channels reload and keep running).
// Ports:
//   clk, reset (sync, active-low)   tick       : one-second pulse
//   load_valid/load_ready/load_ch/load_time    : channel load handshake
//   start_stop/ss_ch                : toggle run state of a channel
//   disp_ch/disp_time               : combinational read of a channel time
//   running/done                    : per-channel run flag and sticky expiry flag
//   done_pulse                      : one clk per expiry
//   busy/overrun                    : sweep in progress / tick lost while busy
module timer_channel_scheduler
  import egg_timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [CHW-1:0]   load_ch,
  input  logic [15:0]      load_time,
  input  logic             start_stop,
  input  logic [CHW-1:0]   ss_ch,
  input  logic [CHW-1:0]   disp_ch,
  output logic [15:0]      disp_time,
  output logic [NCH-1:0]   running,
  output logic [NCH-1:0]   done,
  output logic             done_pulse,
  output logic             busy,
  output logic             overrun
);

  sched_state_t   state_q, state_d;
  logic [CHW-1:0] idx_q, idx_d;
  bcd_time_t      dec_in_q, dec_in_d;
  bcd_time_t      times_q [NCH];
  bcd_time_t      times_d [NCH];
  logic [NCH-1:0] running_q, running_d;
  logic [NCH-1:0] done_q, done_d;
  logic           done_pulse_q, done_pulse_d;
  logic           overrun_q, overrun_d;
  logic           pend_vld_q, pend_vld_d;
  logic [CHW-1:0] pend_ch_q, pend_ch_d;
`ifdef AUTO_RELOAD_EN
  bcd_time_t      reload_q [NCH];
  bcd_time_t      reload_d [NCH];
`endif

  bcd_time_t dec_out;
  logic      is_zero_after;
  logic      load_fire;

  bcd_mmss_dec u_dec (
    .dec_in        (dec_in_q),
    .dec_out       (dec_out),
    .is_zero_after (is_zero_after)
  );

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign load_fire  = load_valid && load_ready;
  assign running    = running_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign overrun    = overrun_q;

  always_comb begin
    disp_time = TIME_ZERO;
    if (int'(disp_ch) < NCH) disp_time = times_q[disp_ch];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dec_in_d     = dec_in_q;
    times_d      = times_q;
    running_d    = running_q;
    done_d       = done_q;
    done_pulse_d = 1'b0;
    overrun_d    = overrun_q;
    pend_vld_d   = pend_vld_q;
    pend_ch_d    = pend_ch_q;
`ifdef AUTO_RELOAD_EN
    reload_d     = reload_q;
`endif

    case (state_q)
      IDLE: begin
        // Toggles are XORed so a direct and a pending toggle both take effect;
        // a load to the same channel this clk overrides either. A channel at
        // 00:00 can never be started.
        if (start_stop && !(load_fire && load_ch == ss_ch) &&
            times_q[ss_ch] != TIME_ZERO)
          running_d[ss_ch] = ~running_d[ss_ch];
        if (pend_vld_q) begin
          pend_vld_d = 1'b0;
          if (!(load_fire && load_ch == pend_ch_q) && times_q[pend_ch_q] != TIME_ZERO)
            running_d[pend_ch_q] = ~running_d[pend_ch_q];
        end
        if (load_fire) begin
          times_d[load_ch]   = clamp_time(load_time);
          running_d[load_ch] = 1'b0;
          done_d[load_ch]    = 1'b0;
`ifdef AUTO_RELOAD_EN
          reload_d[load_ch]  = clamp_time(load_time);
`endif
        end
        if (tick) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        dec_in_d = times_q[idx_q];
        state_d  = WRITE;
      end
      WRITE: begin
        if (running_q[idx_q]) begin
          times_d[idx_q] = dec_out;
          if (is_zero_after) begin
            done_d[idx_q] = 1'b1;
            done_pulse_d  = 1'b1;
`ifdef AUTO_RELOAD_EN
            if (reload_q[idx_q] != TIME_ZERO) times_d[idx_q]   = reload_q[idx_q];
            else                               running_d[idx_q] = 1'b0;
`else
            running_d[idx_q] = 1'b0;
`endif
          end
        end
        if (idx_q == CHW'(NCH - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + CHW'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // While sweeping, ticks are lost (flagged) and one start_stop is deferred.
    if (state_q != IDLE) begin
      if (tick) overrun_d = 1'b1;
      if (start_stop && !pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_ch_d  = ss_ch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dec_in_q     <= TIME_ZERO;
      running_q    <= '0;
      done_q       <= '0;
      done_pulse_q <= 1'b0;
      overrun_q    <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_ch_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        times_q[i]  <= TIME_ZERO;
`ifdef AUTO_RELOAD_EN
        reload_q[i] <= TIME_ZERO;
`endif
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dec_in_q     <= dec_in_d;
      times_q      <= times_d;
      running_q    <= running_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      overrun_q    <= overrun_d;
      pend_vld_q   <= pend_vld_d;
      pend_ch_q    <= pend_ch_d;
`ifdef AUTO_RELOAD_EN
      reload_q     <= reload_d;
`endif
    end
  end

endmodule

// File: tb/tb_timer_channel_scheduler.sv
// Bench for timer_channel_scheduler (NCH=4). A seconds-based model tracks
// every channel and is compared with the DUT on each falling edge; directed
// scenarios add literal expectations.
module tb_timer_channel_scheduler;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic load_valid = 1'b0;
  logic load_ready;
  logic [CHW-1:0] load_ch = '0;
  logic [15:0] load_time = '0;
  logic start_stop = 1'b0;
  logic [CHW-1:0] ss_ch = '0;
  logic [CHW-1:0] disp_ch = '0;
  logic [15:0] disp_time;
  logic [NCH-1:0] running, done;
  logic done_pulse, busy, overrun;

  timer_channel_scheduler #(.NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load_valid(load_valid),
    .load_ready(load_ready), .load_ch(load_ch), .load_time(load_time),
    .start_stop(start_stop), .ss_ch(ss_ch), .disp_ch(disp_ch),
    .disp_time(disp_time), .running(running), .done(done),
    .done_pulse(done_pulse), .busy(busy), .overrun(overrun)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model: times held as whole seconds ----------------
  int m_sec [NCH];
  int m_rel [NCH];
  bit [NCH-1:0] m_run = '0, m_done = '0, tog;
  bit m_ovr = 0, m_pulse = 0, m_pend = 0;
  int m_pend_ch = 0;
  int ph = 0;            // 0 = idle, 1..2*NCH = clk within a sweep
  bit cmp_en = 0;

  function automatic int clamp_sec(input logic [15:0] t);
    int mt, mo, st, so;
    mt = (t[15:12] > 9) ? 9 : int'(t[15:12]);
    mo = (t[11:8]  > 9) ? 9 : int'(t[11:8]);
    st = (t[7:4]   > 5) ? 5 : int'(t[7:4]);
    so = (t[3:0]   > 9) ? 9 : int'(t[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin m_sec[i] = 0; m_rel[i] = 0; end
      m_run = '0; m_done = '0; m_ovr = 0; m_pulse = 0; m_pend = 0; ph = 0;
    end else if (ph != 0) begin
      if (tick) m_ovr = 1;
      if (start_stop && !m_pend) begin m_pend = 1; m_pend_ch = int'(ss_ch); end
      m_pulse = 0;
      if (ph % 2 == 0) begin
        int c;
        c = ph / 2 - 1;
        if (m_run[c]) begin
          m_sec[c] = m_sec[c] - 1;
          if (m_sec[c] == 0) begin
            m_done[c] = 1;
            m_pulse = 1;
`ifdef AUTO_RELOAD_EN
            if (m_rel[c] != 0) m_sec[c] = m_rel[c];
            else m_run[c] = 0;
`else
            m_run[c] = 0;
`endif
          end
        end
      end
      ph = (ph == 2 * NCH) ? 0 : ph + 1;
    end else begin
      m_pulse = 0;
      tog = '0;
      if (start_stop && m_sec[ss_ch] != 0 && !(load_valid && load_ch == ss_ch))
        tog[ss_ch] = ~tog[ss_ch];
      if (m_pend) begin
        m_pend = 0;
        if (m_sec[m_pend_ch] != 0 && !(load_valid && int'(load_ch) == m_pend_ch))
          tog[m_pend_ch] = ~tog[m_pend_ch];
      end
      m_run = m_run ^ tog;
      if (load_valid) begin
        m_sec[load_ch] = clamp_sec(load_time);
        m_rel[load_ch] = clamp_sec(load_time);
        m_run[load_ch] = 0;
        m_done[load_ch] = 0;
      end
      if (tick) ph = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, ph != 0);
      chk("load_ready", load_ready, ph == 0);
      chk("done_pulse", done_pulse, m_pulse);
      chk("running", running, m_run);
      chk("done", done, m_done);
      chk("overrun", overrun, m_ovr);
      chk("disp_time", disp_time, to_bcd(m_sec[disp_ch]));
    end
  end

  // ---------------- stimulus ----------------
  int pcnt;

  task automatic clk1();
    @(posedge clk);
    #1;
    tick = 0; start_stop = 0; load_valid = 0;
    disp_ch = disp_ch + 1'b1;
  endtask

  task automatic sweep(input int n);
    pcnt = 0;
    repeat (n) begin
      clk1();
      if (done_pulse) pcnt++;
    end
  endtask

  task automatic do_load(input int ch, input logic [15:0] t);
    load_valid = 1; load_ch = CHW'(ch); load_time = t;
    clk1();
  endtask

  task automatic do_ss(input int ch);
    start_stop = 1; ss_ch = CHW'(ch);
    clk1();
  endtask

  task automatic peek(input int ch, input logic [15:0] exp, input string name);
    disp_ch = CHW'(ch);
    #1;
    chk(name, disp_time, exp);
  endtask

  initial begin
    reset = 0;
    repeat (3) clk1();
    cmp_en = 1;
    clk1();
    chk("rst_running", running, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", load_ready, 1'b1);
    peek(2, 16'h0000, "rst_time2");
    reset = 1;
    clk1();

    // ch1 01:00 -> 00:59 after one sweep, others untouched
    do_load(1, 16'h0100);
    do_ss(1);
    tick = 1; clk1();
    sweep(2 * NCH);
    chk("sweep_idle", busy, 1'b0);
    peek(1, 16'h0059, "ch1_0059");
    peek(0, 16'h0000, "ch0_unchanged");

    // ch0 00:01 expires: stops, done, one pulse
    do_load(0, 16'h0001);
    do_ss(0);
    tick = 1; clk1();
    sweep(2 * NCH);
    chk("expire_pulses", pcnt, 1);
    chk("expire_running", running, 4'b0010);
    chk("expire_done", done, 4'b0001);
    peek(0, 16'h0000, "ch0_zero");

    // borrow across minutes; clamp of non-BCD load
    do_load(2, 16'h1000);
    do_ss(2);
    tick = 1; clk1();
    sweep(2 * NCH);
    peek(2, 16'h0959, "ch2_0959");
    do_load(3, 16'h9F7A);
    peek(3, 16'h9959, "clamp_9959");

    // tick during sweep dropped, overrun set, single decrement
    tick = 1; clk1();
    clk1(); clk1();
    tick = 1; clk1();
    sweep(2 * NCH - 3);
    chk("overrun_set", overrun, 1'b1);
    peek(1, 16'h0056, "ovr_ch1");
    peek(2, 16'h0958, "ovr_ch2");

    // start_stop deferred to first idle clk; a second one dropped
    tick = 1; clk1();
    do_ss(3);
    do_ss(1);
    sweep(2 * NCH - 2);
    chk("pend_not_yet", running, 4'b0110);
    clk1();
    chk("pend_applied", running, 4'b1110);
    peek(3, 16'h9959, "ch3_not_dec");

    // load vs start_stop: same channel load wins, different channels both apply
    load_valid = 1; load_ch = 3; load_time = 16'h0030;
    start_stop = 1; ss_ch = 3;
    clk1();
    chk("load_wins", running, 4'b0110);
    load_valid = 1; load_ch = 0; load_time = 16'h0005;
    start_stop = 1; ss_ch = 1;
    clk1();
    chk("both_apply", running, 4'b0100);
    peek(0, 16'h0005, "ch0_0005");

    // two expiries in one sweep give two pulses
    do_load(0, 16'h0001);
    do_load(1, 16'h0001);
    do_ss(0);
    do_ss(1);
    tick = 1; clk1();
    sweep(2 * NCH);
    chk("two_pulses", pcnt, 2);
    chk("two_done", done, 4'b0011);
    do_ss(0);
    chk("ss_on_zero", running, 4'b0100);

    // tick and load in the same idle clk
    load_valid = 1; load_ch = 3; load_time = 16'h0100;
    tick = 1;
    clk1();
    sweep(2 * NCH);
    peek(3, 16'h0100, "tick_load_ch3");
    peek(2, 16'h0955, "tick_load_ch2");

    // reset mid-sweep
    tick = 1; clk1();
    clk1(); clk1(); clk1();
    reset = 0;
    clk1();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_running", running, 4'b0000);
    chk("midrst_done", done, 4'b0000);
    chk("midrst_ovr", overrun, 1'b0);
    peek(2, 16'h0000, "midrst_ch2");
    reset = 1;
    clk1();

`ifdef AUTO_RELOAD_EN
    do_load(0, 16'h0002);
    do_ss(0);
    tick = 1; clk1();
    sweep(2 * NCH);
    tick = 1; clk1();
    sweep(2 * NCH);
    chk("reload_pulse", pcnt, 1);
    chk("reload_running", running, 4'b0001);
    chk("reload_done", done, 4'b0001);
    peek(0, 16'h0002, "reload_time");
`endif

    clk1(); clk1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
